// File: rtl/mem_wb_skid.sv
// mem_wb_skid: two-entry MEM->WB skid buffer with registered in_ready and bubble-gated write enables.
module mem_wb_skid #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_wd,
  input  logic [DW-1:0] in_wdata,
  input  logic          in_wreg,
  input  logic          in_whilo,
  input  logic [DW-1:0] in_hi,
  input  logic [DW-1:0] in_lo,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_wd,
  output logic [DW-1:0] out_wdata,
  output logic          out_wreg,
  output logic          out_whilo,
  output logic [DW-1:0] out_hi,
  output logic [DW-1:0] out_lo,
  output logic [1:0]    occupancy
);
  localparam int PW = AW + 2 + 3 * DW;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e        state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic          in_ready_q, accept, consume, wreg_raw, whilo_raw;
  assign in_pl    = {in_wd, in_wdata, in_wreg, in_whilo, in_hi, in_lo};
  assign accept   = in_valid & in_ready_q;
  assign consume  = out_valid & out_ready;
  assign in_ready = in_ready_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= state_d != FULL;
    end
  end
  always_comb begin
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE   ? (accept & ~consume ? FULL : (~accept & consume ? EMPTY : ONE)) :
              (consume ? ONE : FULL);
  end
  // skid only ever receives the younger entry, main refills from skid first
  always_comb begin
    main_d = (state_q == FULL && consume) ? skid_q :
             (accept && (state_q == EMPTY || consume)) ? in_pl : main_q;
    skid_d = (state_q == ONE && accept && !consume) ? in_pl : skid_q;
  end
  always_comb begin
    out_valid = state_q != EMPTY;
    occupancy = state_q == FULL ? 2'd2 : (state_q == ONE ? 2'd1 : 2'd0);
  end
  assign {out_wd, out_wdata, wreg_raw, whilo_raw, out_hi, out_lo} = main_q;
  assign out_wreg  = wreg_raw & out_valid;
  assign out_whilo = whilo_raw & out_valid;
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: table-driven corner cases plus randomized run against a queue-based reference model.
module tb_mem_wb_skid;
  logic        clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_wd, out_wd;
  logic [31:0] in_wdata, in_hi, in_lo, out_wdata, out_hi, out_lo;
  logic        in_wreg, in_whilo, out_wreg, out_whilo;
  logic [1:0]  occupancy;
  int total = 0, bad = 0;

  mem_wb_skid #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wdata(in_wdata), .in_wreg(in_wreg), .in_whilo(in_whilo),
    .in_hi(in_hi), .in_lo(in_lo), .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wdata(out_wdata), .out_wreg(out_wreg), .out_whilo(out_whilo),
    .out_hi(out_hi), .out_lo(out_lo), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg, whilo;
    logic [31:0] hi, lo;
  } pl_t;

  typedef struct {
    logic r, fl, iv, ordy;
    pl_t  in;
    logic [1:0] occ;
    logic ov, ir, cp;
    pl_t  exp;
  } vec_t;

  function automatic pl_t p(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg, whilo,
                            input logic [31:0] hi, lo);
    p.wd = wd; p.wdata = wdata; p.wreg = wreg; p.whilo = whilo; p.hi = hi; p.lo = lo;
  endfunction

  function automatic vec_t mk(input logic r, fl, iv, ordy, input pl_t in, input logic [1:0] occ,
                              input logic ov, ir, cp, input pl_t exp);
    mk.r = r; mk.fl = fl; mk.iv = iv; mk.ordy = ordy; mk.in = in;
    mk.occ = occ; mk.ov = ov; mk.ir = ir; mk.cp = cp; mk.exp = exp;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, fl, iv, ordy, input pl_t in);
    rst = r; flush = fl; in_valid = iv; out_ready = ordy;
    in_wd = in.wd; in_wdata = in.wdata; in_wreg = in.wreg; in_whilo = in.whilo;
    in_hi = in.hi; in_lo = in.lo;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pl(input string tag, input pl_t e);
    chk({tag, ".wd"}, out_wd, e.wd);
    chk({tag, ".wdata"}, out_wdata, e.wdata);
    chk({tag, ".hi"}, out_hi, e.hi);
    chk({tag, ".lo"}, out_lo, e.lo);
  endtask

  vec_t tbl[16];
  pl_t  z, hl, q[$], cur;
  logic rdy_m, acc;

  initial begin
    z  = p(0, 0, 0, 0, 0, 0);
    hl = p(7, 32'h1, 0, 1, 32'h12345678, 32'h9ABCDEF0);
    tbl[0]  = mk(1, 0, 0, 0, z, 0, 0, 1, 1, z);
    tbl[1]  = mk(0, 0, 0, 1, p(2, 32'hF, 1, 1, 1, 1), 0, 0, 1, 1, z);
    tbl[2]  = mk(0, 0, 1, 0, p(3, 32'hA, 1, 0, 0, 0), 1, 1, 1, 1, p(3, 32'hA, 1, 0, 0, 0));
    tbl[3]  = mk(0, 0, 1, 0, p(4, 32'hB, 1, 0, 0, 0), 2, 1, 0, 1, p(3, 32'hA, 1, 0, 0, 0));
    tbl[4]  = mk(0, 0, 1, 0, p(5, 32'hC, 1, 0, 0, 0), 2, 1, 0, 1, p(3, 32'hA, 1, 0, 0, 0));
    tbl[5]  = mk(0, 0, 0, 1, z, 1, 1, 1, 1, p(4, 32'hB, 1, 0, 0, 0));
    tbl[6]  = mk(0, 0, 0, 1, z, 0, 0, 1, 0, z);
    tbl[7]  = mk(0, 0, 1, 1, hl, 1, 1, 1, 1, hl);
    tbl[8]  = mk(0, 0, 1, 0, p(8, 32'h11, 1, 0, 0, 0), 2, 1, 0, 1, hl);
    tbl[9]  = mk(0, 1, 1, 0, p(9, 32'h99, 1, 1, 0, 0), 0, 0, 1, 0, z);
    tbl[10] = mk(0, 0, 0, 1, z, 0, 0, 1, 0, z);
    tbl[11] = mk(0, 0, 1, 0, p(1, 32'h21, 1, 0, 0, 0), 1, 1, 1, 1, p(1, 32'h21, 1, 0, 0, 0));
    tbl[12] = mk(0, 0, 1, 0, p(2, 32'h22, 1, 0, 0, 0), 2, 1, 0, 1, p(1, 32'h21, 1, 0, 0, 0));
    tbl[13] = mk(1, 0, 1, 0, p(3, 32'h23, 1, 1, 5, 5), 0, 0, 1, 1, z);
    tbl[14] = mk(0, 0, 1, 1, p(9, 32'h55, 1, 0, 0, 0), 1, 1, 1, 1, p(9, 32'h55, 1, 0, 0, 0));
    tbl[15] = mk(0, 0, 0, 1, z, 0, 0, 1, 0, z);
    foreach (tbl[i]) begin
      string t;
      t = $sformatf("row%0d", i);
      drive(tbl[i].r, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].in);
      chk({t, ".occ"}, occupancy, tbl[i].occ);
      chk({t, ".out_valid"}, out_valid, tbl[i].ov);
      chk({t, ".in_ready"}, in_ready, tbl[i].ir);
      chk({t, ".wreg"}, out_wreg, tbl[i].ov & tbl[i].exp.wreg);
      chk({t, ".whilo"}, out_whilo, tbl[i].ov & tbl[i].exp.whilo);
      if (tbl[i].cp) chk_pl(t, tbl[i].exp);
    end
    // streaming: one-cycle latency, buffer never fills
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, 1, p(5'(i), 32'(i), 1, 0, 0, 0));
      chk($sformatf("stream%0d.wdata", i), out_wdata, i);
      chk($sformatf("stream%0d.occ", i), occupancy, 1);
      chk($sformatf("stream%0d.in_ready", i), in_ready, 1);
    end
    // randomized run against a FIFO-of-two reference model
    drive(1, 0, 0, 0, z);
    q.delete();
    rdy_m = 1;
    for (int n = 0; n < 600; n++) begin
      logic r, fl, iv, ordy;
      r = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 39) == 0);
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      cur = p(5'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
      if (r || fl) q.delete();
      else begin
        acc = iv && rdy_m;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
      rdy_m = q.size() < 2;
      drive(r, fl, iv, ordy, cur);
      chk("rnd.occ", occupancy, q.size());
      chk("rnd.out_valid", out_valid, q.size() > 0);
      chk("rnd.in_ready", in_ready, rdy_m);
      if (q.size() > 0) begin
        chk_pl("rnd", q[0]);
        chk("rnd.wreg", out_wreg, q[0].wreg);
        chk("rnd.whilo", out_whilo, q[0].whilo);
      end else begin
        chk("rnd.wreg", out_wreg, 0);
        chk("rnd.whilo", out_whilo, 0);
        if (r) chk_pl("rnd.rst", z);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
